// File: rtl/traffic_pkg.sv
// Shared traffic-light definitions: sensor-conditioner FSM state encoding and
// default timing constants, also reused by the controller bench.
package traffic_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAITING = 2'd1,
    REQUEST = 2'd2,
    SERVING = 2'd3
  } vs_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_CNT_W           = 4;
  localparam int DEF_THRESHOLD       = 2;
  localparam int DEF_MAX_WAIT        = 64;

  // Register width able to hold 0..n-1, never narrower than one bit.
  function automatic int min_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vs_debounce.sv
// Loop-contact front end: 2-FF synchronizer, stability-count debouncer and a
// registered one-cycle arrival pulse on each debounced rising edge.
module vs_debounce
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_loop,
  output logic o_deb,
  output logic o_rise,
  output logic o_arrival
);

  localparam int             SW        = min_width(DEBOUNCE_CYCLES);
  localparam logic [SW-1:0]  STAB_LAST = SW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q, s2_q;
  logic          deb_q, deb_d;
  logic          deb_dly_q;
  logic          arr_q;
  logic [SW-1:0] stab_q, stab_d;

  // The counter holds the number of cycles s2 has already differed, so the
  // level flips on the DEBOUNCE_CYCLES-th differing cycle.
  always_comb begin
    deb_d  = deb_q;
    stab_d = '0;
    if (s2_q != deb_q) begin
      if (stab_q == STAB_LAST) begin
        deb_d = s2_q;
      end else begin
        stab_d = stab_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      deb_q     <= 1'b0;
      stab_q    <= '0;
      deb_dly_q <= 1'b0;
      arr_q     <= 1'b0;
    end else begin
      s1_q      <= i_loop;
      s2_q      <= s1_q;
      deb_q     <= deb_d;
      stab_q    <= stab_d;
      deb_dly_q <= deb_q;
      arr_q     <= deb_q & ~deb_dly_q;
    end
  end

  assign o_deb     = deb_q;
  assign o_rise    = deb_q & ~deb_dly_q;
  assign o_arrival = arr_q;

endmodule

// File: rtl/vehicle_sensor_conditioner.sv
// Side-road vehicle request generator: debounced loop, queued-vehicle counter
// and request FSM. Define VS_MAXWAIT_EN to add the forced-request wait timer.
module vehicle_sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W,
  parameter int THRESHOLD       = DEF_THRESHOLD,
  parameter int MAX_WAIT        = DEF_MAX_WAIT
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_loop,
  input  logic             i_side_green,
  output logic             o_Vs,
  output logic             o_arrival,
  output logic [CNT_W-1:0] o_vehicle_count
);

  localparam logic [CNT_W-1:0] CNT_THR = CNT_W'(THRESHOLD);

  vs_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             deb;
  logic             rise;
  logic             wait_done;

  vs_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_loop    (i_loop),
    .o_deb     (deb),
    .o_rise    (rise),
    .o_arrival (o_arrival)
  );

  // Counting uses the same-cycle debounced rise so the count moves together
  // with the registered arrival pulse.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == SERVING || i_side_green) begin
      cnt_d = '0;
    end else if (rise && cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

`ifdef VS_MAXWAIT_EN
  localparam int            WW        = min_width(MAX_WAIT);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

  logic [WW-1:0] wait_q, wait_d;

  always_comb begin
    wait_d = '0;
    if (state_q == WAITING) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end

  assign wait_done = (wait_q == WAIT_LAST);
`else
  // No timer; MAX_WAIT stays referenced so both builds share one parameter list.
  assign wait_done = 1'b0 & (MAX_WAIT > 0);
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (i_side_green)        state_d = SERVING;
        else if (cnt_q != '0)    state_d = WAITING;
      end
      WAITING: begin
        if (i_side_green)        state_d = SERVING;
        else if (cnt_q >= CNT_THR) state_d = REQUEST;
        else if (wait_done)      state_d = REQUEST;
      end
      REQUEST: begin
        if (i_side_green)        state_d = SERVING;
      end
      SERVING: begin
        if (!i_side_green)       state_d = IDLE;
      end
      default:                   state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_Vs            = (state_q == REQUEST) | ((state_q == SERVING) & deb);
  assign o_vehicle_count = cnt_q;

endmodule
